simple_fifo: RTL and testbench

//  Synchronous circular-buffer FIFO: the design-under-test side of the push/pop/data_in/data_out

---
 rtl/simple_fifo.sv | 99 +++++++++
 tb/tb_simple_fifo.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/simple_fifo.sv
// Circular-buffer FIFO with show-ahead output, count-based full/empty and sticky
// overflow/underflow flags for requests that had to be dropped.
module simple_fifo #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int PTRWID = $clog2(DEPTH),
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              empty,
    output logic              full,
    output logic [CNTWID-1:0] count,
    output logic              push_ok,
    output logic              pop_ok,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [CNTWID-1:0] DEPTH_C = CNTWID'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTRWID-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRWID-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTWID-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // Full/empty come from the occupancy count only; equal pointers are ambiguous.
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign data_out = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTRWID'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTRWID'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNTWID'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNTWID'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is cleared on reset so the head word is deterministic for formal tools.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= DEPTH_C);
            assert ((wr_ptr_q - rd_ptr_q) == count_q[PTRWID-1:0]);
            assert (!(empty && full));
            assert (!push_ok || !full);
            assert (!pop_ok || !empty);
        end
    end

endmodule

// File: tb/tb_simple_fifo.sv
// Bench for simple_fifo: directed scenarios plus biased random push/pop traffic,
// compared each cycle against a queue-based reference model.
module tb_simple_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             empty, full, push_ok, pop_ok, overflow, underflow;
    logic [3:0]       count;

    int errs = 0;
    int checks = 0;

    logic [WIDTH-1:0] mdl_q[$];
    bit               mdl_ovf = 1'b0;
    bit               mdl_unf = 1'b0;

    simple_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in),
        .data_out(data_out), .empty(empty), .full(full), .count(count),
        .push_ok(push_ok), .pop_ok(pop_ok), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mdl_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mdl_q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mdl_q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(mdl_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(mdl_unf));
        if (mdl_q.size() > 0) begin
            chk({tag, ".data_out"}, 32'(data_out), 32'(mdl_q[0]));
        end
    endtask

    // One clock cycle of traffic; entered and left just after a rising edge.
    task automatic cyc(input string tag, input bit p, input bit r, input logic [WIDTH-1:0] d);
        bit acc_p, acc_r;
        push = p;
        pop = r;
        data_in = d;
        #3;
        acc_p = p && (mdl_q.size() < DEPTH);
        acc_r = r && (mdl_q.size() > 0);
        chk({tag, ".push_ok"}, 32'(push_ok), 32'(acc_p));
        chk({tag, ".pop_ok"}, 32'(pop_ok), 32'(acc_r));
        if (p && !acc_p) mdl_ovf = 1'b1;
        if (r && !acc_r) mdl_unf = 1'b1;
        @(posedge clk);
        if (acc_r) void'(mdl_q.pop_front());
        if (acc_p) mdl_q.push_back(d);
        #1;
        push = 1'b0;
        pop = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        push = 1'b0;
        pop = 1'b0;
        rst = 1'b1;
        #1;
        mdl_q.delete();
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
        check_state(tag);
        chk({tag, ".data_out0"}, 32'(data_out), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // Pop on empty right after reset.
        cyc("pop_empty", 1'b0, 1'b1, 8'h00);

        do_reset("t1_rst");
        cyc("t1_push", 1'b1, 1'b0, 8'hA1);
        cyc("t1_push", 1'b1, 1'b0, 8'hB2);
        cyc("t1_push", 1'b1, 1'b0, 8'hC3);
        chk("t1_head", 32'(data_out), 32'hA1);
        repeat (3) cyc("t1_pop", 1'b0, 1'b1, 8'h00);

        // Fill, overflow, drain.
        for (int i = 0; i < DEPTH; i++) cyc("t2_fill", 1'b1, 1'b0, WIDTH'(8'h10 + i));
        cyc("t2_over", 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_order", 32'(data_out), 32'(8'h10 + i));
            cyc("t2_drain", 1'b0, 1'b1, 8'h00);
        end

        // Steady-state push&pop across pointer wrap.
        do_reset("t4_rst");
        for (int i = 0; i < 4; i++) cyc("t4_fill", 1'b1, 1'b0, WIDTH'(8'h40 + i));
        for (int i = 0; i < 20; i++) cyc("t4_pp", 1'b1, 1'b1, WIDTH'(i));

        // Simultaneous push&pop on empty and on full.
        do_reset("t5_rst");
        cyc("t5_empty", 1'b1, 1'b1, 8'h5A);
        chk("t5_head", 32'(data_out), 32'h5A);
        for (int i = 1; i < DEPTH; i++) cyc("t5_fill", 1'b1, 1'b0, WIDTH'(8'h60 + i));
        cyc("t5_full", 1'b1, 1'b1, 8'hEE);
        chk("t5_cnt7", 32'(count), 32'd7);
        while (mdl_q.size() > 0) cyc("t5_drain", 1'b0, 1'b1, 8'h00);

        // Reset mid-stream.
        do_reset("t6_rst0");
        for (int i = 0; i < 5; i++) cyc("t6_fill", 1'b1, 1'b0, WIDTH'(8'h20 + i));
        do_reset("t6_rst");
        cyc("t6_push", 1'b1, 1'b0, 8'h33);
        chk("t6_head", 32'(data_out), 32'h33);
        cyc("t6_pop", 1'b0, 1'b1, 8'h00);

        // Biased random traffic: push-heavy, pop-heavy, balanced, saturating.
        for (int ph = 0; ph < 4; ph++) begin
            int pp;
            int rp;
            pp = (ph == 0) ? 75 : (ph == 1) ? 25 : (ph == 2) ? 50 : 95;
            rp = (ph == 3) ? 40 : 100 - pp;
            for (int i = 0; i < 150; i++) begin
                cyc("rand", $urandom_range(0, 99) < pp, $urandom_range(0, 99) < rp,
                    WIDTH'($urandom));
            end
            if (ph == 1) do_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
